// File: rtl/mc_main_control.sv
// mc_main_control: multi-cycle main control FSM for the mips16 datapath (FETCH/DECODE/EXECUTE/MEM/WB).
// Define MC_INSTR_COUNT_EN to build the retired-instruction counter; otherwise instr_count is tied to 0.
module mc_main_control #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_cond_ne,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count
);
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LI   = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    WB_R     = 4'd3,
    EXEC_I   = 4'd4,
    WB_I     = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    WB_MEM   = 4'd8,
    MEM_WR   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JR       = 4'd12,
    HALT     = 4'd15
  } state_t;

  state_t        state, nxt;
  logic [WW-1:0] wait_cnt;
  logic          mem_st, timeout;

  // next-state: opcode dispatch in DECODE, handshake stalls, and the memory timeout override
  always_comb begin
    mem_st  = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    timeout = mem_st && !mem_ready && (wait_cnt == WW'(WAIT_MAX - 1));
    nxt     = state;
    case (state)
      FETCH:    nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_R:                                        nxt = (func == FN_JR) ? JR : EXEC_R;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LI:    nxt = EXEC_I;
          OP_LW, OP_SW:                                nxt = MEM_ADDR;
          OP_BEQ, OP_BNE:                              nxt = BRANCH;
          OP_J, OP_JAL:                                nxt = JUMP;
          default:                                     nxt = HALT;
        endcase
      end
      EXEC_R:   nxt = WB_R;
      EXEC_I:   nxt = WB_I;
      MEM_ADDR: nxt = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   nxt = mem_ready ? WB_MEM : MEM_RD;
      MEM_WR:   nxt = mem_ready ? FETCH : MEM_WR;
      WB_R, WB_I, WB_MEM, BRANCH, JUMP, JR: nxt = FETCH;
      default:  nxt = HALT;
    endcase
    if (timeout) nxt = HALT;
  end

  // state, wait counter and sticky halt flag; reset drops straight back to FETCH so no write is left pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      wait_cnt <= '0;
      illegal  <= 1'b0;
    end else begin
      state    <= nxt;
      wait_cnt <= (mem_st && !mem_ready) ? wait_cnt + 1'b1 : '0;
      illegal  <= illegal | (state == HALT);
    end
  end

  // Moore decode of the current state; only FETCH gates its loads with mem_ready
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_cond_ne    = 1'b0;
    pc_src        = 2'b00;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE:   alu_src_b = 2'b11;
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b110;
      end
      WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == OP_SLTI) ? 3'b101 : (opcode == OP_ANDI) ? 3'b010 : (opcode == OP_ORI) ? 3'b011 : 3'b000;
      end
      WB_I:     reg_write = 1'b1;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_cond_ne    = (opcode == OP_BNE);
        pc_src        = 2'b01;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        reg_write  = (opcode == OP_JAL);
        reg_dst    = (opcode == OP_JAL) ? 2'b10 : 2'b00;
        mem_to_reg = (opcode == OP_JAL) ? 2'b10 : 2'b00;
      end
      JR: begin
        pc_write = 1'b1;
        pc_src   = 2'b11;
      end
      default: ;
    endcase
  end

  assign state_o = state;

`ifdef MC_INSTR_COUNT_EN
  logic             retire;
  logic [CNT_W-1:0] cnt;
  assign retire = (nxt == FETCH) && ((state == WB_R) || (state == WB_I) || (state == WB_MEM) ||
                  (state == MEM_WR) || (state == BRANCH) || (state == JUMP) || (state == JR));
  // retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (retire) cnt <= cnt + 1'b1;
  end
  assign instr_count = cnt;
`else
  assign instr_count = '0;
`endif
endmodule
